// File: rtl/spi_cfg_master.sv
// spi_cfg_master
// SPI master for single-byte register access to an FPGA/ADC configuration
// port. A local controller requests one read or write at a time. The block
// sends a 24-bit frame in SPI mode 0, MSB first:
//   [23] R/W, [22:21] W1:W0 = 00, [20:8] address (zero-extended), [7:0] data.
// For reads the data byte is sent as zeros, and the bits the slave returns
// during that byte appear on O_rdata.
//
// Handshake: I_req is a level. It is sampled only in IDLE. The accept edge
// raises O_ack for one cycle and latches I_rw, I_addr and I_wdata. O_busy
// stays high from accept until O_done. O_done is a one-cycle pulse.
// Requests made while busy get no ack.
//
// Timing relative to the accept edge T0 (C = CLK_DIV):
//   rising  O_sclk of bit k  at T0 + (2k+1)*C   (I_sdo sampled on this edge)
//   falling O_sclk of bit k  at T0 + (2k+2)*C   (O_sdi advances on this edge)
//   _O_csb high              at T0 + 49*C
//   O_done                   at T0 + 50*C
//
// Ports:
//   I_clk, _I_rst                   clock, async active-low reset
//   I_req, I_rw, I_addr, I_wdata    request side
//   O_ack, O_busy, O_done, O_rdata  status and read data
//   O_sclk, _O_csb, O_sdi, I_sdo    SPI pins
//   O_state                         debug view of the FSM state
module spi_cfg_master #(
  parameter int ADDR_SIZE = 8,
  parameter int CLK_DIV   = 4
) (
  input  logic                 I_clk,
  input  logic                 _I_rst,
  input  logic                 I_req,
  input  logic                 I_rw,
  input  logic [ADDR_SIZE-1:0] I_addr,
  input  logic [7:0]           I_wdata,
  output logic                 O_ack,
  output logic                 O_busy,
  output logic                 O_done,
  output logic [7:0]           O_rdata,
  output logic                 O_sclk,
  output logic                 _O_csb,
  output logic                 O_sdi,
  input  logic                 I_sdo,
  output logic [2:0]           O_state
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;    // half-period down-counter
  logic [4:0]       bit_q, bit_d;    // index k of the bit on the wire
  logic [23:0]      tx_q, tx_d;      // bits still to be driven, MSB next
  logic [7:0]       rx_q, rx_d;      // read-data shift register
  logic             rw_q, rw_d;

  logic             ack_d, busy_d, done_d, sclk_d, csb_d, sdi_d;
  logic [7:0]       rdata_d;
  logic [12:0]      addr_ext;
  logic [23:0]      frame;
  logic             boundary;

  assign O_state = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rw_d    = rw_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    busy_d  = O_busy;
    rdata_d = O_rdata;
    sclk_d  = O_sclk;
    csb_d   = _O_csb;
    sdi_d   = O_sdi;

    addr_ext                 = '0;
    addr_ext[ADDR_SIZE-1:0]  = I_addr;
    frame    = {I_rw, 2'b00, addr_ext, (I_rw ? 8'h00 : I_wdata)};
    boundary = (cnt_q == '0);

    if (state_q == IDLE) begin
      if (I_req) begin
        // Bit 23 goes out now. The rest is held shifted so that each falling
        // edge takes tx_q[23]. Zeros shift in behind, so O_sdi returns to 0
        // after the last bit.
        rw_d    = I_rw;
        tx_d    = {frame[22:0], 1'b0};
        sdi_d   = frame[23];
        ack_d   = 1'b1;
        busy_d  = 1'b1;
        csb_d   = 1'b0;
        cnt_d   = CNT_RELOAD;
        bit_d   = 5'd0;
        state_d = SETUP;
      end
    end else if (!boundary) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      // Reloading at every phase boundary keeps each phase exactly CLK_DIV
      // cycles long for the whole frame.
      cnt_d = CNT_RELOAD;
      unique case (state_q)
        SETUP: begin
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end
        SHIFT: begin
          if (!O_sclk) begin
            // Rising edge. I_sdo still holds the value the slave drove
            // during the low phase that just ended.
            sclk_d = 1'b1;
            if (bit_q[4]) rx_d = {rx_q[6:0], I_sdo};
          end else begin
            sclk_d = 1'b0;
            sdi_d  = tx_q[23];
            tx_d   = {tx_q[22:0], 1'b0};
            if (bit_q == 5'd23) state_d = HOLD;
            else                bit_d   = bit_q + 5'd1;
          end
        end
        HOLD: begin
          csb_d   = 1'b1;
          state_d = GAP;
        end
        GAP: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          if (rw_q) rdata_d = rx_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk or negedge _I_rst) begin
    if (!_I_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rw_q    <= 1'b0;
      O_ack   <= 1'b0;
      O_busy  <= 1'b0;
      O_done  <= 1'b0;
      O_rdata <= 8'h00;
      O_sclk  <= 1'b0;
      _O_csb  <= 1'b1;
      O_sdi   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rw_q    <= rw_d;
      O_ack   <= ack_d;
      O_busy  <= busy_d;
      O_done  <= done_d;
      O_rdata <= rdata_d;
      O_sclk  <= sclk_d;
      _O_csb  <= csb_d;
      O_sdi   <= sdi_d;
    end
  end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Testbench for spi_cfg_master. One instance runs at CLK_DIV=4 and one at
// CLK_DIV=2. A shared slave model watches whichever instance is selected.
module tb_spi_cfg_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req, rw, sel;
  logic [7:0] addr, wdata;
  logic       sdo;

  logic       ack4, busy4, done4, sclk4, csb4, sdi4;
  logic       ack2, busy2, done2, sclk2, csb2, sdi2;
  logic [7:0] rdata4, rdata2;
  logic [2:0] state4, state2;
  logic       req4, req2;

  assign req4 = req & ~sel;
  assign req2 = req & sel;

  spi_cfg_master #(.ADDR_SIZE(8), .CLK_DIV(4)) u4 (
    .I_clk(clk), ._I_rst(rst_n), .I_req(req4), .I_rw(rw), .I_addr(addr),
    .I_wdata(wdata), .O_ack(ack4), .O_busy(busy4), .O_done(done4),
    .O_rdata(rdata4), .O_sclk(sclk4), ._O_csb(csb4), .O_sdi(sdi4),
    .I_sdo(sdo), .O_state(state4)
  );

  spi_cfg_master #(.ADDR_SIZE(8), .CLK_DIV(2)) u2 (
    .I_clk(clk), ._I_rst(rst_n), .I_req(req2), .I_rw(rw), .I_addr(addr),
    .I_wdata(wdata), .O_ack(ack2), .O_busy(busy2), .O_done(done2),
    .O_rdata(rdata2), .O_sclk(sclk2), ._O_csb(csb2), .O_sdi(sdi2),
    .I_sdo(sdo), .O_state(state2)
  );

  logic       ack, busy, done, sclk, csb, sdi;
  logic [7:0] rdata;
  logic [2:0] state;
  assign ack   = sel ? ack2   : ack4;
  assign busy  = sel ? busy2  : busy4;
  assign done  = sel ? done2  : done4;
  assign sclk  = sel ? sclk2  : sclk4;
  assign csb   = sel ? csb2   : csb4;
  assign sdi   = sel ? sdi2   : sdi4;
  assign rdata = sel ? rdata2 : rdata4;
  assign state = sel ? state2 : state4;

  // ---------------- slave model ----------------
  // Captures sdi on rising sclk. Drives sbyte on sdo MSB first, changing on
  // falling sclk, so bit 7 is on the wire before data-phase rise k=16.
  logic [23:0] cap;
  logic [7:0]  sbyte;
  int          rises, falls;
  logic        csb_p, sclk_p;

  initial begin
    cap = '0; rises = 0; falls = 0; sdo = 1'b0; sbyte = 8'h00;
    csb_p = 1'b1; sclk_p = 1'b0;
  end

  always @(csb or sclk) begin
    if (csb_p === 1'b1 && csb === 1'b0) begin
      cap = '0; rises = 0; falls = 0; sdo = 1'b0;
    end else if (csb === 1'b0) begin
      if (sclk_p === 1'b0 && sclk === 1'b1) begin
        cap = {cap[22:0], sdi};
        rises++;
      end
      if (sclk_p === 1'b1 && sclk === 1'b0) begin
        falls++;
        if (falls >= 16 && falls <= 23) sdo = sbyte[3'(23 - falls)];
        else                            sdo = 1'b0;
      end
    end
    csb_p  = csb;
    sclk_p = sclk;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Runs until O_done, for at most limit cycles. Samples on negedges.
  task automatic wait_done(input int limit, output int cyc, output int lowc,
                           output int hic, output int acks, output int period,
                           output bit ok);
    logic prev;
    int   nr, r1, r2;
    cyc = 0; lowc = 0; hic = 0; acks = 0; ok = 1'b0; nr = 0; r1 = 0; r2 = 0;
    prev = sclk;
    while (!ok && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (!csb) lowc++; else hic++;
      if (ack) acks++;
      if (sclk && !prev) begin
        nr++;
        if (nr == 1) r1 = cyc;
        if (nr == 2) r2 = cyc;
      end
      prev = sclk;
      if (done) ok = 1'b1;
    end
    period = r2 - r1;
  endtask

  task automatic run_txn(input bit s, input bit r, input logic [7:0] a,
                         input logic [7:0] wd, input logic [7:0] sb,
                         input logic [7:0] er, input string nm);
    int cd, cyc, lowc, hic, acks, per;
    bit ok;
    logic [23:0] ef;
    cd = s ? 2 : 4;
    ef = {r, 2'b00, 5'b00000, a, (r ? 8'h00 : wd)};
    exp_q.push_back(ef);
    @(negedge clk);
    sel = s; rw = r; addr = a; wdata = wd; sbyte = sb; req = 1'b1;
    @(negedge clk);
    chk({nm, " ack"}, 32'(ack), 1);
    chk({nm, " busy"}, 32'(busy), 1);
    chk({nm, " csb_low"}, 32'(csb), 0);
    chk({nm, " sdi_bit23"}, 32'(sdi), 32'(ef[23]));
    // After accept, input changes must not reach the frame in flight.
    req = 1'b0; addr = ~a; wdata = ~wd; rw = ~r;
    wait_done(60 * cd, cyc, lowc, hic, acks, per, ok);
    chk({nm, " done_seen"}, 32'(ok), 1);
    chk({nm, " latency"}, cyc, 50 * cd);
    chk({nm, " csb_low_cycles"}, lowc + 1, 49 * cd);
    chk({nm, " csb_gap"}, hic, cd + 1);
    chk({nm, " sclk_period"}, per, 2 * cd);
    chk({nm, " extra_ack"}, acks, 0);
    chk({nm, " rises"}, rises, 24);
    chk({nm, " frame"}, 32'(cap), 32'(exp_q.pop_front()));
    chk({nm, " rdata"}, 32'(rdata), 32'(er));
    chk({nm, " busy_end"}, 32'(busy), 0);
    @(negedge clk);
    chk({nm, " done_pulse"}, 32'(done), 0);
    chk({nm, " state_idle"}, 32'(state), 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit         rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] sbyte;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cyc, lowc, hic, acks, per, guard, dcnt;
    bit ok;

    vecs[0] = '{1'b0, 8'h06, 8'hA5, 8'h00, 8'h00};  // frame 0x0006A5
    vecs[1] = '{1'b1, 8'h06, 8'h00, 8'h3C, 8'h3C};  // frame 0x800600
    vecs[2] = '{1'b0, 8'h7F, 8'h12, 8'hFF, 8'h3C};  // write keeps old rdata
    vecs[3] = '{1'b1, 8'hFF, 8'h77, 8'h81, 8'h81};  // frame 0x80FF00

    rst_n = 1'b0; req = 1'b0; rw = 1'b0; sel = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset csb4", 32'(csb4), 1);
    chk("reset sclk4", 32'(sclk4), 0);
    chk("reset sdi4", 32'(sdi4), 0);
    chk("reset ack_busy_done4", {29'd0, ack4, busy4, done4}, 0);
    chk("reset rdata4", 32'(rdata4), 0);
    chk("reset state4", 32'(state4), 0);
    chk("reset csb2", 32'(csb2), 1);
    chk("reset rdata2", 32'(rdata2), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_txn(1'b0, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].sbyte,
              vecs[i].exp_rdata, $sformatf("vec%0d", i));

    // Request held high across two transactions.
    @(negedge clk);
    sel = 1'b0; rw = 1'b0; addr = 8'h10; wdata = 8'h11; req = 1'b1;
    @(negedge clk);
    chk("hold ack1", 32'(ack), 1);
    addr = 8'h20; wdata = 8'h22;
    wait_done(300, cyc, lowc, hic, acks, per, ok);
    chk("hold done1", 32'(ok), 1);
    chk("hold latency1", cyc, 200);
    chk("hold frame1", 32'(cap), 32'h001011);
    chk("hold csb_gap", hic, 5);
    @(negedge clk);
    chk("hold ack2_after_done", 32'(ack), 1);
    chk("hold csb_low2", 32'(csb), 0);
    req = 1'b0;
    wait_done(300, cyc, lowc, hic, acks, per, ok);
    chk("hold done2", 32'(ok), 1);
    chk("hold frame2", 32'(cap), 32'h002022);

    // Request pulse and address change during SHIFT.
    @(negedge clk);
    rw = 1'b0; addr = 8'h33; wdata = 8'h44; req = 1'b1;
    @(negedge clk);
    chk("busyreq ack", 32'(ack), 1);
    req = 1'b0;
    guard = 0;
    while (rises < 5 && guard < 200) begin @(negedge clk); guard++; end
    chk("busyreq reach_shift", 32'(rises >= 5), 1);
    req = 1'b1; addr = 8'h99; wdata = 8'h00;
    @(negedge clk);
    req = 1'b0;
    wait_done(300, cyc, lowc, hic, acks, per, ok);
    chk("busyreq no_ack", acks + 32'(ack), 0);
    chk("busyreq done", 32'(ok), 1);
    chk("busyreq frame", 32'(cap), 32'h003344);
    dcnt = 0;
    repeat (20) begin @(negedge clk); if (done) dcnt++; end
    chk("busyreq single_done", dcnt, 0);

    // Reset during bit 10 of a write.
    @(negedge clk);
    rw = 1'b0; addr = 8'h02; wdata = 8'hFF; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    guard = 0;
    while (rises < 10 && guard < 200) begin @(negedge clk); guard++; end
    chk("rst reach_bit10", rises, 10);
    rst_n = 1'b0;
    #1;
    chk("rst csb", 32'(csb), 1);
    chk("rst sclk", 32'(sclk), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst rdata", 32'(rdata), 0);
    dcnt = 0;
    repeat (5) begin @(negedge clk); if (done) dcnt++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done) dcnt++; end
    chk("rst no_done", dcnt, 0);
    run_txn(1'b0, 1'b0, 8'h01, 8'h55, 8'h00, 8'h00, "post_rst");

    // CLK_DIV=2 read.
    run_txn(1'b1, 1'b1, 8'h5A, 8'h00, 8'hFF, 8'hFF, "div2_read");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
